// File: rtl/rs_br.sv
// In-order reservation station for the branch unit: circular queue of branch/JAL/JALR ops.
// Operands are captured from two CDB ports, and the head entry issues once it is complete.
module rs_br #(
  parameter int ENTRY_NUM = 4,
  parameter int TAG_W     = 6,
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int ALU_OP_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_flush,
  input  logic                i_disp_vld,
  output logic                o_disp_rdy,
  input  logic                i_disp_is_jal,
  input  logic                i_disp_is_jalr,
  input  logic [ALU_OP_W-1:0] i_disp_alu_op,
  input  logic [DATA_W-1:0]   i_disp_rs1,
  input  logic                i_disp_rs1_rdy,
  input  logic [TAG_W-1:0]    i_disp_rs1_tag,
  input  logic [DATA_W-1:0]   i_disp_rs2,
  input  logic                i_disp_rs2_rdy,
  input  logic [TAG_W-1:0]    i_disp_rs2_tag,
  input  logic [PC_W-1:0]     i_disp_pc,
  input  logic [DATA_W-1:0]   i_disp_imm,
  input  logic [PC_W-1:0]     i_disp_pred,
  input  logic [TAG_W-1:0]    i_disp_rob_tag,
  input  logic                i_cdb0_vld,
  input  logic [TAG_W-1:0]    i_cdb0_tag,
  input  logic [DATA_W-1:0]   i_cdb0_data,
  input  logic                i_cdb1_vld,
  input  logic [TAG_W-1:0]    i_cdb1_tag,
  input  logic [DATA_W-1:0]   i_cdb1_data,
  input  logic                i_ex_accessable,
  output logic                o_is_vld,
  output logic                o_is_jal,
  output logic                o_is_jalr,
  output logic [ALU_OP_W-1:0] o_alu_op,
  output logic [DATA_W-1:0]   o_rs1,
  output logic [DATA_W-1:0]   o_rs2,
  output logic [PC_W-1:0]     o_pc,
  output logic [DATA_W-1:0]   o_imm,
  output logic [PC_W-1:0]     o_pred,
  output logic [TAG_W-1:0]    o_rob_tag
);

  localparam int PTR_W = $clog2(ENTRY_NUM);
  localparam int CNT_W = PTR_W + 1;

  logic                valid_q   [ENTRY_NUM];
  logic                is_jal_q  [ENTRY_NUM];
  logic                is_jalr_q [ENTRY_NUM];
  logic [ALU_OP_W-1:0] alu_op_q  [ENTRY_NUM];
  logic [DATA_W-1:0]   rs1_q     [ENTRY_NUM];
  logic                rs1_rdy_q [ENTRY_NUM];
  logic [TAG_W-1:0]    rs1_tag_q [ENTRY_NUM];
  logic [DATA_W-1:0]   rs2_q     [ENTRY_NUM];
  logic                rs2_rdy_q [ENTRY_NUM];
  logic [TAG_W-1:0]    rs2_tag_q [ENTRY_NUM];
  logic [PC_W-1:0]     pc_q      [ENTRY_NUM];
  logic [DATA_W-1:0]   imm_q     [ENTRY_NUM];
  logic [PC_W-1:0]     pred_q    [ENTRY_NUM];
  logic [TAG_W-1:0]    rob_tag_q [ENTRY_NUM];

  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;

  logic              disp_acc;
  logic              disp_rs1_rdy, disp_rs2_rdy;
  logic [DATA_W-1:0] disp_rs1, disp_rs2;

  // Handshakes: a dispatch transfers on any edge where i_disp_vld && o_disp_rdy (and no flush);
  // o_disp_rdy depends on registered count only. An issue transfers on every edge where o_is_vld
  // is high; the branch unit has already granted it through i_ex_accessable.
  assign o_disp_rdy = (count_q != CNT_W'(ENTRY_NUM));
  assign disp_acc   = i_disp_vld && o_disp_rdy && !i_flush;
  assign o_is_vld   = valid_q[head_q] && rs1_rdy_q[head_q] && rs2_rdy_q[head_q]
                      && i_ex_accessable && !i_flush;

  assign o_is_jal  = is_jal_q[head_q];
  assign o_is_jalr = is_jalr_q[head_q];
  assign o_alu_op  = alu_op_q[head_q];
  assign o_rs1     = rs1_q[head_q];
  assign o_rs2     = rs2_q[head_q];
  assign o_pc      = pc_q[head_q];
  assign o_imm     = imm_q[head_q];
  assign o_pred    = pred_q[head_q];
  assign o_rob_tag = rob_tag_q[head_q];

  // Dispatch-time bypass: a missing operand broadcast in the dispatch cycle is stored as ready.
  always_comb begin
    disp_rs1_rdy = i_disp_rs1_rdy;
    disp_rs1     = i_disp_rs1;
    disp_rs2_rdy = i_disp_rs2_rdy;
    disp_rs2     = i_disp_rs2;
    if (!i_disp_rs1_rdy) begin
      if (i_cdb0_vld && (i_cdb0_tag == i_disp_rs1_tag)) begin
        disp_rs1_rdy = 1'b1;
        disp_rs1     = i_cdb0_data;
      end else if (i_cdb1_vld && (i_cdb1_tag == i_disp_rs1_tag)) begin
        disp_rs1_rdy = 1'b1;
        disp_rs1     = i_cdb1_data;
      end
    end
    if (!i_disp_rs2_rdy) begin
      if (i_cdb0_vld && (i_cdb0_tag == i_disp_rs2_tag)) begin
        disp_rs2_rdy = 1'b1;
        disp_rs2     = i_cdb0_data;
      end else if (i_cdb1_vld && (i_cdb1_tag == i_disp_rs2_tag)) begin
        disp_rs2_rdy = 1'b1;
        disp_rs2     = i_cdb1_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        valid_q[i]   <= 1'b0;
        is_jal_q[i]  <= 1'b0;
        is_jalr_q[i] <= 1'b0;
        alu_op_q[i]  <= '0;
        rs1_q[i]     <= '0;
        rs1_rdy_q[i] <= 1'b0;
        rs1_tag_q[i] <= '0;
        rs2_q[i]     <= '0;
        rs2_rdy_q[i] <= 1'b0;
        rs2_tag_q[i] <= '0;
        pc_q[i]      <= '0;
        imm_q[i]     <= '0;
        pred_q[i]    <= '0;
        rob_tag_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (i_flush) begin
      for (int i = 0; i < ENTRY_NUM; i++) valid_q[i] <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // Wakeup; port 0 wins when both ports carry the awaited tag.
      for (int i = 0; i < ENTRY_NUM; i++) begin
        if (valid_q[i] && !rs1_rdy_q[i]) begin
          if (i_cdb0_vld && (i_cdb0_tag == rs1_tag_q[i])) begin
            rs1_q[i]     <= i_cdb0_data;
            rs1_rdy_q[i] <= 1'b1;
          end else if (i_cdb1_vld && (i_cdb1_tag == rs1_tag_q[i])) begin
            rs1_q[i]     <= i_cdb1_data;
            rs1_rdy_q[i] <= 1'b1;
          end
        end
        if (valid_q[i] && !rs2_rdy_q[i]) begin
          if (i_cdb0_vld && (i_cdb0_tag == rs2_tag_q[i])) begin
            rs2_q[i]     <= i_cdb0_data;
            rs2_rdy_q[i] <= 1'b1;
          end else if (i_cdb1_vld && (i_cdb1_tag == rs2_tag_q[i])) begin
            rs2_q[i]     <= i_cdb1_data;
            rs2_rdy_q[i] <= 1'b1;
          end
        end
      end
      if (o_is_vld) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      if (disp_acc) begin
        valid_q[tail_q]   <= 1'b1;
        is_jal_q[tail_q]  <= i_disp_is_jal;
        is_jalr_q[tail_q] <= i_disp_is_jalr;
        alu_op_q[tail_q]  <= i_disp_alu_op;
        rs1_q[tail_q]     <= disp_rs1;
        rs1_rdy_q[tail_q] <= disp_rs1_rdy;
        rs1_tag_q[tail_q] <= i_disp_rs1_tag;
        rs2_q[tail_q]     <= disp_rs2;
        rs2_rdy_q[tail_q] <= disp_rs2_rdy;
        rs2_tag_q[tail_q] <= i_disp_rs2_tag;
        pc_q[tail_q]      <= i_disp_pc;
        imm_q[tail_q]     <= i_disp_imm;
        pred_q[tail_q]    <= i_disp_pred;
        rob_tag_q[tail_q] <= i_disp_rob_tag;
        tail_q            <= tail_q + 1'b1;
      end
      case ({disp_acc, o_is_vld})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_rs_br.sv
// Bench for rs_br: a queue-level model of the station checked every cycle, plus directed
// scenarios with literal expectations on issue timing, ordering, flush and async reset.
module tb_rs_br;

  localparam int N = 4;

  typedef struct packed {
    logic        jal;
    logic        jalr;
    logic [3:0]  alu;
    logic [31:0] rs1;
    logic        r1rdy;
    logic [5:0]  t1;
    logic [31:0] rs2;
    logic        r2rdy;
    logic [5:0]  t2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] pred;
    logic [5:0]  rob;
  } entry_t;

  logic        clk, rst_n, i_flush, i_disp_vld, o_disp_rdy;
  logic        i_disp_is_jal, i_disp_is_jalr;
  logic [3:0]  i_disp_alu_op;
  logic [31:0] i_disp_rs1, i_disp_rs2, i_disp_pc, i_disp_imm, i_disp_pred;
  logic        i_disp_rs1_rdy, i_disp_rs2_rdy;
  logic [5:0]  i_disp_rs1_tag, i_disp_rs2_tag, i_disp_rob_tag;
  logic        i_cdb0_vld, i_cdb1_vld;
  logic [5:0]  i_cdb0_tag, i_cdb1_tag;
  logic [31:0] i_cdb0_data, i_cdb1_data;
  logic        i_ex_accessable, o_is_vld, o_is_jal, o_is_jalr;
  logic [3:0]  o_alu_op;
  logic [31:0] o_rs1, o_rs2, o_pc, o_imm, o_pred;
  logic [5:0]  o_rob_tag;

  int checks   = 0;
  int failures = 0;

  entry_t exp_q[$];

  rs_br #(.ENTRY_NUM(N), .TAG_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .i_flush(i_flush),
    .i_disp_vld(i_disp_vld), .o_disp_rdy(o_disp_rdy),
    .i_disp_is_jal(i_disp_is_jal), .i_disp_is_jalr(i_disp_is_jalr), .i_disp_alu_op(i_disp_alu_op),
    .i_disp_rs1(i_disp_rs1), .i_disp_rs1_rdy(i_disp_rs1_rdy), .i_disp_rs1_tag(i_disp_rs1_tag),
    .i_disp_rs2(i_disp_rs2), .i_disp_rs2_rdy(i_disp_rs2_rdy), .i_disp_rs2_tag(i_disp_rs2_tag),
    .i_disp_pc(i_disp_pc), .i_disp_imm(i_disp_imm), .i_disp_pred(i_disp_pred),
    .i_disp_rob_tag(i_disp_rob_tag),
    .i_cdb0_vld(i_cdb0_vld), .i_cdb0_tag(i_cdb0_tag), .i_cdb0_data(i_cdb0_data),
    .i_cdb1_vld(i_cdb1_vld), .i_cdb1_tag(i_cdb1_tag), .i_cdb1_data(i_cdb1_data),
    .i_ex_accessable(i_ex_accessable),
    .o_is_vld(o_is_vld), .o_is_jal(o_is_jal), .o_is_jalr(o_is_jalr), .o_alu_op(o_alu_op),
    .o_rs1(o_rs1), .o_rs2(o_rs2), .o_pc(o_pc), .o_imm(o_imm), .o_pred(o_pred),
    .o_rob_tag(o_rob_tag)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic entry_t wake(entry_t e);
    entry_t r = e;
    if (!r.r1rdy) begin
      if (i_cdb0_vld && i_cdb0_tag == r.t1) begin r.rs1 = i_cdb0_data; r.r1rdy = 1'b1; end
      else if (i_cdb1_vld && i_cdb1_tag == r.t1) begin r.rs1 = i_cdb1_data; r.r1rdy = 1'b1; end
    end
    if (!r.r2rdy) begin
      if (i_cdb0_vld && i_cdb0_tag == r.t2) begin r.rs2 = i_cdb0_data; r.r2rdy = 1'b1; end
      else if (i_cdb1_vld && i_cdb1_tag == r.t2) begin r.rs2 = i_cdb1_data; r.r2rdy = 1'b1; end
    end
    return r;
  endfunction

  // Behavioural model: the station is an ordered list of ops; the oldest issues when complete.
  always @(posedge clk or negedge rst_n) begin : model
    entry_t e;
    bit iss, acc;
    if (!rst_n || i_flush) begin
      exp_q.delete();
    end else begin
      iss = exp_q.size() > 0 && exp_q[0].r1rdy && exp_q[0].r2rdy && i_ex_accessable;
      acc = i_disp_vld && exp_q.size() < N;
      for (int i = 0; i < exp_q.size(); i++) exp_q[i] = wake(exp_q[i]);
      if (iss) void'(exp_q.pop_front());
      if (acc) begin
        e.jal = i_disp_is_jal;   e.jalr = i_disp_is_jalr; e.alu = i_disp_alu_op;
        e.rs1 = i_disp_rs1;      e.r1rdy = i_disp_rs1_rdy; e.t1 = i_disp_rs1_tag;
        e.rs2 = i_disp_rs2;      e.r2rdy = i_disp_rs2_rdy; e.t2 = i_disp_rs2_tag;
        e.pc = i_disp_pc;        e.imm = i_disp_imm;       e.pred = i_disp_pred;
        e.rob = i_disp_rob_tag;
        exp_q.push_back(wake(e));
      end
    end
  end

  // Compare process, mid-cycle while inputs are stable.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_disp_rdy", o_disp_rdy, exp_q.size() != N);
      chk("m_is_vld", o_is_vld, exp_q.size() > 0 && exp_q[0].r1rdy && exp_q[0].r2rdy
                                 && i_ex_accessable && !i_flush);
      if (exp_q.size() > 0) begin
        chk("m_jal", o_is_jal, exp_q[0].jal);
        chk("m_jalr", o_is_jalr, exp_q[0].jalr);
        chk("m_alu_op", o_alu_op, exp_q[0].alu);
        chk("m_pc", o_pc, exp_q[0].pc);
        chk("m_imm", o_imm, exp_q[0].imm);
        chk("m_pred", o_pred, exp_q[0].pred);
        chk("m_rob_tag", o_rob_tag, exp_q[0].rob);
        if (exp_q[0].r1rdy) chk("m_rs1", o_rs1, exp_q[0].rs1);
        if (exp_q[0].r2rdy) chk("m_rs2", o_rs2, exp_q[0].rs2);
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    i_disp_vld = 1'b0;
    i_cdb0_vld = 1'b0;
    i_cdb1_vld = 1'b0;
    i_flush    = 1'b0;
  endtask

  task automatic set_disp(input logic [5:0] rob, input logic [31:0] r1, input logic r1rdy,
                          input logic [5:0] t1, input logic [31:0] r2, input logic r2rdy,
                          input logic [5:0] t2);
    i_disp_vld     = 1'b1;
    i_disp_rob_tag = rob;
    i_disp_rs1     = r1;
    i_disp_rs1_rdy = r1rdy;
    i_disp_rs1_tag = t1;
    i_disp_rs2     = r2;
    i_disp_rs2_rdy = r2rdy;
    i_disp_rs2_tag = t2;
    i_disp_alu_op  = rob[3:0];
    i_disp_is_jal  = (rob == 6'd3);
    i_disp_is_jalr = (rob == 6'd4);
    i_disp_pc      = 32'h1000 + {24'd0, rob, 2'b00};
    i_disp_imm     = 32'h40 + {26'd0, rob};
    i_disp_pred    = i_disp_pc + i_disp_imm;
  endtask

  initial begin
    rst_n = 1'b1;
    i_ex_accessable = 1'b0;
    i_cdb0_tag = '0; i_cdb0_data = '0; i_cdb1_tag = '0; i_cdb1_data = '0;
    set_disp(6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0);
    clr();
    #2 rst_n = 1'b0;
    step();
    step();
    chk("rst_is_vld", o_is_vld, 0);
    chk("rst_disp_rdy", o_disp_rdy, 1);
    chk("rst_rob_tag", o_rob_tag, 0);
    chk("rst_rs1", o_rs1, 0);
    rst_n = 1'b1;

    // 1: both operands ready -> issue next cycle, then empty
    step(); i_ex_accessable = 1'b1; set_disp(6'd1, 32'd5, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0);
    #1 chk("t1_not_same_cycle", o_is_vld, 0);
    step(); clr();
    #1 chk("t1_is_vld", o_is_vld, 1); chk("t1_rs1", o_rs1, 5); chk("t1_rs2", o_rs2, 5);
    chk("t1_rob", o_rob_tag, 1);
    step(); #1 chk("t1_empty", o_is_vld, 0); chk("t1_disp_rdy", o_disp_rdy, 1);

    // 2: rs2 woken by cdb1 two cycles after dispatch
    set_disp(6'd2, 32'd3, 1'b1, 6'd0, 32'd0, 1'b0, 6'h12);
    step(); clr(); #1 chk("t2_wait1", o_is_vld, 0);
    step(); i_cdb1_vld = 1'b1; i_cdb1_tag = 6'h12; i_cdb1_data = 32'hABCD;
    #1 chk("t2_no_bypass", o_is_vld, 0);
    step(); clr(); #1 chk("t2_is_vld", o_is_vld, 1); chk("t2_rs2", o_rs2, 32'hABCD);
    chk("t2_rob", o_rob_tag, 2);
    step(); #1 chk("t2_empty", o_is_vld, 0);

    // 3: dispatch-time bypass from cdb0
    set_disp(6'd3, 32'd0, 1'b0, 6'h07, 32'd4, 1'b1, 6'd0);
    i_cdb0_vld = 1'b1; i_cdb0_tag = 6'h07; i_cdb0_data = 32'd9;
    step(); clr(); #1 chk("t3_is_vld", o_is_vld, 1); chk("t3_rs1", o_rs1, 9);
    chk("t3_jal", o_is_jal, 1);
    step(); #1 chk("t3_empty", o_is_vld, 0);

    // 4: fill, ignored 5th, then in-order drain
    i_ex_accessable = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      set_disp(6'(k), 32'(k), 1'b1, 6'd0, 32'(k + 100), 1'b1, 6'd0);
      step();
    end
    clr(); #1 chk("t4_full", o_disp_rdy, 0);
    set_disp(6'd5, 32'd5, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0);
    step(); clr(); i_ex_accessable = 1'b1;
    #1 chk("t4_full_after_5th", o_disp_rdy, 0); chk("t4_iss1", o_is_vld, 1);
    chk("t4_rob1", o_rob_tag, 1);
    for (int k = 2; k <= 4; k++) begin
      step(); #1 chk("t4_iss", o_is_vld, 1); chk("t4_rob", o_rob_tag, 6'(k));
      chk("t4_rdy_back", o_disp_rdy, 1);
    end
    step(); #1 chk("t4_drained", o_is_vld, 0); chk("t4_disp_rdy", o_disp_rdy, 1);

    // 5: stalled head blocks a ready younger entry
    set_disp(6'd10, 32'd0, 1'b0, 6'h20, 32'd7, 1'b1, 6'd0);
    step(); set_disp(6'd11, 32'd1, 1'b1, 6'd0, 32'd2, 1'b1, 6'd0);
    step(); clr(); #1 chk("t5_block1", o_is_vld, 0);
    step(); #1 chk("t5_block2", o_is_vld, 0);
    i_cdb0_vld = 1'b1; i_cdb0_tag = 6'h20; i_cdb0_data = 32'h55;
    #1 chk("t5_block3", o_is_vld, 0);
    step(); clr(); #1 chk("t5_head", o_is_vld, 1); chk("t5_head_rob", o_rob_tag, 10);
    chk("t5_head_rs1", o_rs1, 32'h55);
    step(); #1 chk("t5_second", o_is_vld, 1); chk("t5_second_rob", o_rob_tag, 11);
    step(); #1 chk("t5_empty", o_is_vld, 0);

    // 6: flush with a concurrent dispatch, then async reset mid-cycle
    i_ex_accessable = 1'b0;
    for (int k = 20; k <= 22; k++) begin
      set_disp(6'(k), 32'd1, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0);
      step();
    end
    set_disp(6'd23, 32'd1, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0);
    i_flush = 1'b1; i_ex_accessable = 1'b1;
    #1 chk("t6_flush_blocks_issue", o_is_vld, 0);
    step(); clr(); #1 chk("t6_after_flush_vld", o_is_vld, 0);
    chk("t6_after_flush_rdy", o_disp_rdy, 1);
    i_ex_accessable = 1'b0;
    for (int k = 30; k <= 33; k++) begin
      set_disp(6'(k), 32'd2, 1'b1, 6'd0, 32'd2, 1'b1, 6'd0);
      step();
    end
    clr(); #1 chk("t6_full", o_disp_rdy, 0); chk("t6_head_rob", o_rob_tag, 30);
    #2 rst_n = 1'b0;
    #1 chk("t6_async_rdy", o_disp_rdy, 1); chk("t6_async_rob", o_rob_tag, 0);
    chk("t6_async_vld", o_is_vld, 0);
    step(); rst_n = 1'b1; i_ex_accessable = 1'b1;
    step(); set_disp(6'd40, 32'd8, 1'b1, 6'd0, 32'd8, 1'b1, 6'd0);
    step(); clr(); #1 chk("t6_post_reset_iss", o_is_vld, 1); chk("t6_post_reset_rob", o_rob_tag, 40);
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
